// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// =============================================================================
// Module   : div_pkg
// Brief    : Shared width constants and FSM state type for the restoring divider.
// Revision : 1.0
// =============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// =============================================================================
// Module   : seq_restoring_divider_if
// Brief    : start/busy/done handshake and operand/result bus of the divider.
// Revision : 1.0
// =============================================================================
interface seq_restoring_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, divzero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, divzero
    );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider_restoring_div_step.sv
`default_nettype none
// =============================================================================
// Module   : restoring_div_step
// Brief    : One combinational restoring-division iteration (inverted-divisor add).
// Revision : 1.0
// =============================================================================
module restoring_div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic [WIDTH-1:0] i_rem,
    input  wire logic             i_dvd_bit,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH-1:0] o_rem,
    output logic                  o_q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sum_lo;

    // Shifted partial is WIDTH+1 bits; a set top bit already guarantees no
    // borrow, so only the low WIDTH bits need to go through the adder.
    always_comb begin
        shifted = {i_rem, i_dvd_bit};
        sum_lo  = {1'b0, shifted[WIDTH-1:0]} + {1'b0, ~i_divisor}
                + {{WIDTH{1'b0}}, 1'b1};
        o_q_bit = shifted[WIDTH] | sum_lo[WIDTH];
        o_rem   = o_q_bit ? sum_lo[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// =============================================================================
// Module   : seq_restoring_divider
// Brief    : Multi-cycle restoring divider, one quotient bit per clock.
//            Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
// Revision : 1.0
// =============================================================================
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic                clk,
    input  wire logic                reset,
    seq_restoring_divider_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;
    logic             accept;

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (rem_q),
        .i_dvd_bit (dvd_q[WIDTH-1]),
        .i_divisor (dvs_q),
        .o_rem     (step_rem),
        .o_q_bit   (step_bit)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    // Magnitude of 0x8000 is 0x8000 read as unsigned, so no overflow case here.
    always_comb begin
        a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        if (dvs_q == '0) begin
            fin_q = '1;
            fin_r = neg_rem_q ? -dvd_q : dvd_q;
        end else begin
            fin_q = neg_quo_q ? -dvd_q : dvd_q;
            fin_r = neg_rem_q ? -rem_q : rem_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_d = bus.dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
        fin_q = (dvs_q == '0) ? '1 : dvd_q;
        fin_r = (dvs_q == '0) ? dvd_q : rem_q;
    end
`endif

    // A start in the FINISH cycle is accepted so operations can run back to back.
    assign accept = bus.start && ((state_q == IDLE) || (state_q == FINISH));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        divzero_d   = divzero_q;
        done_d      = 1'b0;

        case (state_q)
            RUN: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_bit};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                quotient_d  = fin_q;
                remainder_d = fin_r;
                divzero_d   = (dvs_q == '0);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The finishing op's divzero flag wins over the clear on a back-to-back start.
        if (accept) begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            count_d = '0;
            if (state_q == IDLE) begin
                divzero_d = 1'b0;
            end
            if (bus.divisor == '0) begin
                state_d = FINISH;
                busy_d  = 1'b0;
            end else begin
                state_d = RUN;
                busy_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divzero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            divzero_q   <= divzero_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.divzero   = divzero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// =============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Directed scoreboard bench for seq_restoring_divider.
// Revision : 1.0
// =============================================================================
module tb_seq_restoring_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        string        tag;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_q(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return '1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (a == 16'h8000 && b == 16'hFFFF) return 16'h8000;
        return W'($signed(a) / $signed(b));
`else
        return a / b;
`endif
    endfunction

    function automatic logic [W-1:0] model_r(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return a;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (a == 16'h8000 && b == 16'hFFFF) return '0;
        return W'($signed(a) % $signed(b));
`else
        return a % b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        exp_t e;
        e.q   = model_q(a, b);
        e.r   = model_r(a, b);
        e.dz  = (b == '0);
        e.lat = (b == '0) ? 1 : W + 1;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        push(a, b, tag);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int n_start);
        int   n;
        bit   got;
        exp_t e;
        n   = n_start;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n++;
            if (bus.done) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({e.tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({e.tag, "_latency"}, n, e.lat);
            chk({e.tag, "_quotient"}, bus.quotient, e.q);
            chk({e.tag, "_remainder"}, bus.remainder, e.r);
            chk({e.tag, "_divzero"}, bus.divzero, e.dz);
        end
    endtask

    initial begin
        int seen;
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_divzero", bus.divzero, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic division with latency and single-cycle done pulse.
        issue(16'd100, 16'd7, "div100_7");
        chk("div100_7_busy", bus.busy, 1);
        wait_done(0);
        chk("div100_7_busy_end", bus.busy, 0);
        @(posedge clk);
        #1;
        chk("div100_7_done_pulse", bus.done, 0);

        // Back-to-back: second start lands in the FINISH cycle of the first.
        issue(16'd65535, 16'd1, "b2b_a");
        repeat (16) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.dividend = 16'd3;
        bus.divisor  = 16'd10;
        push(16'd3, 16'd10, "b2b_b");
        wait_done(16);
        chk("b2b_busy_second", bus.busy, 1);
        wait_done(0);

        // Divide by zero.
        issue(16'd5, 16'd0, "div5_0");
        chk("div5_0_busy", bus.busy, 0);
        wait_done(0);
        chk("div5_0_busy_end", bus.busy, 0);

        // Start while busy is ignored.
        issue(16'd1000, 16'd3, "div1000_3");
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.dividend = 16'd9;
        bus.divisor  = 16'd9;
        wait_done(4);
        chk("div1000_3_divzero_clr", bus.divzero, 0);

        // Reset mid-operation aborts with no done pulse.
        issue(16'd50000, 16'd123, "abort");
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        void'(sb.pop_front());
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        chk("abort_no_done", seen, 0);
        issue(16'd50000, 16'd123, "div50000_123");
        wait_done(0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        issue(16'hFFF9, 16'd2, "s_m7_2");
        wait_done(0);
        issue(16'd7, 16'hFFFE, "s_7_m2");
        wait_done(0);
        issue(16'h8000, 16'hFFFF, "s_min_m1");
        wait_done(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle 16-bit integer divider; the subtractive inverse of the datapath fast adder.
- Computes quotient and remainder by restoring division, one bit per clock.
- Each trial subtraction is done as an add of the inverted divisor with carry-in 1.
- Sits beside the ALU as a long-latency functional unit with a start/busy/done handshake to the control FSM.

Parameters:
- WIDTH, 16, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled on rising clk.
- dividend  input  WIDTH  numerator; captured when start is accepted.
- divisor  input  WIDTH  denominator; captured when start is accepted.
- quotient  output  WIDTH  result quotient; registered.
- remainder  output  WIDTH  result remainder; registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- divzero  output  1  set with done when divisor was 0; held until next accepted start.

Behaviour:
- Reset: one clock, reset is asynchronous and active-high. Reset forces state IDLE; quotient, remainder, busy, done, divzero and all internal registers go to 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, FINISH.
- IDLE: start=1 at edge k is accepted.
  - Divisor != 0: latch operands, count=0, clear divzero, go RUN, busy=1 from edge k.
  - Divisor == 0: go FINISH directly, busy stays 0.
- RUN: each edge performs one restoring step.
  - Shift {rem, dvd} left 1.
  - Trial = rem - divisor, done as rem + ~divisor + 1.
  - If no borrow (carry-out 1): rem = trial and the new quotient bit is 1. Otherwise rem is restored and the bit is 0.
  - count increments each step. After WIDTH steps, go FINISH.
- FINISH (one cycle):
  - Normal case: quotient and remainder registers loaded, done=1, busy=0, then IDLE.
  - Divide-by-zero case: quotient = all ones, remainder = dividend, divzero=1, done=1.
- Latency:
  - Normal: done high in cycle WIDTH+1 after the accepting edge (17 for WIDTH=16).
  - Divide by zero: done high in cycle 1 after the accepting edge.
- start while busy=1 is ignored; operands are not re-captured.
- start asserted during the FINISH cycle is accepted (back-to-back ops). done still pulses for the finishing op.
- quotient, remainder and divzero hold their values until the next FINISH or reset.
- Unsigned arithmetic by default. Remainder is always < divisor when divisor != 0.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are divided, then signs are corrected in FINISH.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - The most-negative value divided by -1 yields quotient 0x8000, remainder 0.
  - Correction adds no cycles.
- Undefined: purely unsigned, no sign logic synthesized.

Decomposition:
- Shared package div_pkg holds:
  - DIV_WIDTH constant (16).
  - div_state_t enum {IDLE, RUN, FINISH}.
  - Count width constant, $clog2(DIV_WIDTH)+1.
- One natural sub-module, restoring_div_step: combinational single iteration.
  - Inputs: partial rem, next dividend bit, divisor.
  - Outputs: next rem and quotient bit.
  - Built on the inverted-operand add.

Test Plan:
- 100 / 7, start one cycle -> done at cycle 17, quotient 14, remainder 2, divzero 0.
- 65535 / 1, then 3 / 10 back-to-back (start during FINISH) -> 65535 r0, then 0 r3; two done pulses 17 cycles apart.
- 5 / 0 -> done at cycle 1, divzero 1, quotient 0xFFFF, remainder 5, busy never high.
- Start 1000 / 3, pulse start again at cycle 5 with 9 / 9 -> second request ignored; result 333 r1.
- Start 50000 / 123, assert reset at cycle 8 -> all outputs 0, IDLE, no done. A new 50000 / 123 then gives 406 r62.
- With SEQ_DIVIDER_SIGNED_EN: -7 / 2 -> -3 r -1; 7 / -2 -> -3 r 1; -32768 / -1 -> 0x8000 r 0.
